// File: rtl/ctrl_unit_hardwired.sv
// ctrl_unit_hardwired
//   Hardwired Moore control unit for the datapath. Runs the fetch
//   sequence (T0..T2), decodes IR[31:27] in DEC and executes br, jr, jal,
//   halt; every other opcode behaves as nop and returns to T0.
//
// Ports
//   clock         system clock, rising edge
//   clr           asynchronous active-low reset
//   IR            instruction register contents (opcode in [31:27])
//   CONFFOut      branch condition flip-flop output
//   stop          halt request, honoured only in T0
//   enc_input     bus encoder one-hot select
//   reg_enable    register load enables
//   ALU_Sel       ALU operation
//   read, write   memory strobes (write is never used by this subset)
//   incPC         PC increment
//   Gra/Grb/Grc   select-encode field selects
//   Rin/Rout/BAout general register in / out / base-address out
//   conIn         CON FF load
//   run           1 while executing, 0 in HALT or reset
//   present_state current state code (debug)
//
// state | meaning
// ------+-----------------------------------------------
// T0    | MAR <- PC, PC incremented
// T1    | MDR <- memory
// T2    | IR <- MDR
// DEC   | dispatch on opcode
// BR3   | CON FF evaluates R[ra] against IR[20:19]
// BR4   | Y <- PC
// BR5   | Z <- Y + C (sign-extended offset)
// BR6   | PC <- Zlow when CON FF is set
// JR3   | PC <- R[ra]
// JAL3  | R15 <- PC (select-encode routes all-zero selects to R15)
// JAL4  | PC <- R[ra]
// HALT  | stopped, only clr leaves
// RST   | held in reset
module ctrl_unit_hardwired #(
  parameter logic [5:0] ALU_ADD = 6'd3,
  parameter logic [4:0] OP_BR   = 5'b10010,
  parameter logic [4:0] OP_JR   = 5'b10011,
  parameter logic [4:0] OP_JAL  = 5'b10100,
  parameter logic [4:0] OP_HALT = 5'b11010
) (
  input  logic        clock,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CONFFOut,
  input  logic        stop,
  output logic [31:0] enc_input,
  output logic [31:0] reg_enable,
  output logic [5:0]  ALU_Sel,
  output logic        read,
  output logic        write,
  output logic        incPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        conIn,
  output logic        run,
  output logic [3:0]  present_state
);

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_DEC  = 4'd3,
    S_BR3  = 4'd4,
    S_BR4  = 4'd5,
    S_BR5  = 4'd6,
    S_BR6  = 4'd7,
    S_JR3  = 4'd8,
    S_JAL3 = 4'd9,
    S_JAL4 = 4'd10,
    S_HALT = 4'd14,
    S_RST  = 4'd15
  } state_t;

  // Bit positions on the encoder / enable buses.
  localparam int B_Z   = 19;
  localparam int B_PC  = 20;
  localparam int B_IR  = 21;
  localparam int B_MDR = 22;
  localparam int B_MAR = 23;
  localparam int B_Y   = 24;
  localparam int B_C   = 25;

  state_t state, state_nxt;
  logic [4:0] opcode;

  assign opcode = IR[31:27];

  // Operand fields are consumed by the datapath's select-encode logic,
  // only the opcode steers the sequence here.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) state <= S_RST;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RST:  state_nxt = S_T0;
      S_T0:   state_nxt = stop ? S_HALT : S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2:   state_nxt = S_DEC;
      S_DEC: begin
        if      (opcode == OP_BR)   state_nxt = S_BR3;
        else if (opcode == OP_JR)   state_nxt = S_JR3;
        else if (opcode == OP_JAL)  state_nxt = S_JAL3;
        else if (opcode == OP_HALT) state_nxt = S_HALT;
        else                        state_nxt = S_T0;
      end
      S_BR3:  state_nxt = S_BR4;
      S_BR4:  state_nxt = S_BR5;
      S_BR5:  state_nxt = S_BR6;
      S_BR6:  state_nxt = S_T0;
      S_JR3:  state_nxt = S_T0;
      S_JAL3: state_nxt = S_JAL4;
      S_JAL4: state_nxt = S_T0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  always_comb begin
    enc_input  = '0;
    reg_enable = '0;
    ALU_Sel    = '0;
    read       = 1'b0;
    write      = 1'b0;
    incPC      = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    conIn      = 1'b0;
    run        = 1'b1;
    unique case (state)
      S_T0: begin
        enc_input[B_PC]   = 1'b1;
        reg_enable[B_MAR] = 1'b1;
        incPC             = 1'b1;
      end
      S_T1: begin
        read              = 1'b1;
        reg_enable[B_MDR] = 1'b1;
      end
      S_T2: begin
        enc_input[B_MDR] = 1'b1;
        reg_enable[B_IR] = 1'b1;
      end
      S_DEC: ;
      S_BR3: begin
        Gra   = 1'b1;
        Rout  = 1'b1;
        conIn = 1'b1;
      end
      S_BR4: begin
        enc_input[B_PC] = 1'b1;
        reg_enable[B_Y] = 1'b1;
      end
      S_BR5: begin
        enc_input[B_C]  = 1'b1;
        ALU_Sel         = ALU_ADD;
        reg_enable[B_Z] = 1'b1;
      end
      S_BR6: begin
        // CON FF has been stable since BR4, so gating PC load directly is safe.
        enc_input[B_Z]   = 1'b1;
        reg_enable[B_PC] = CONFFOut;
      end
      S_JR3, S_JAL4: begin
        Gra              = 1'b1;
        Rout             = 1'b1;
        reg_enable[B_PC] = 1'b1;
      end
      S_JAL3: begin
        enc_input[B_PC] = 1'b1;
        Rin             = 1'b1;
      end
      default: run = 1'b0;
    endcase
  end

  assign present_state = state;

endmodule

// File: doc/ctrl_unit_hardwired.md
Name: ctrl_unit_hardwired

Overview:
- Hardwired control unit that drives the datapath's control inputs: encoder selects, register enables, ALU select, memory strobes, PC increment, select-encode and CON FF signals.
- Runs a fixed fetch sequence, then decodes IR and executes the branch/jump class (br, jr, jal), nop and halt. Other opcodes are treated as nop.
- Replaces hand-driven testbench state machines; connects directly to the datapath's control ports.

Parameters:
- ALU_ADD, 6'd3, ALU_Sel code for add.
- OP_BR, 5'b10010, IR[31:27] opcode for br.
- OP_JR, 5'b10011, opcode for jr.
- OP_JAL, 5'b10100, opcode for jal.
- OP_HALT, 5'b11010, opcode for halt.

Ports:
- clock  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- IR  in  32  datapath instruction register contents.
- CONFFOut  in  1  branch condition flip-flop output.
- stop  in  1  synchronous halt request, sampled only in T0.
- enc_input  out  32  bus encoder one-hot select: PC=20, Zlow=19, MDR=22, Y=24, C=25.
- reg_enable  out  32  register load enables: PC=20, IR=21, MDR=22, MAR=23, Y=24, Z=19.
- ALU_Sel  out  6  ALU operation.
- read  out  1  memory read / MDR from memory.
- write  out  1  memory write; held 0 for this instruction subset.
- incPC  out  1  PC increment.
- Gra, Grb, Grc  out  1 each  select-encode field selects.
- Rin, Rout, BAout  out  1 each  general register in/out, base-address out.
- conIn  out  1  CON FF load.
- run  out  1  1 while executing, 0 when halted.
- present_state  out  4  current state code, for debug.

Behaviour:
- Reset: clr=0 asynchronously forces state RST (4'hF); every control output is 0 and run=0.
- Release: first rising edge after clr=1 moves to T0 with run=1.
- Moore machine: one state per clock; all outputs are decoded from the state register only. Any signal not listed for a state is 0.
- State encodings: T0=0, T1=1, T2=2, DEC=3, BR3=4, BR4=5, BR5=6, BR6=7, JR3=8, JAL3=9, JAL4=10, HALT=14, RST=15.
- T0: enc_input[20], reg_enable[23], incPC.
  - If stop=1 at the T0 edge: next state is HALT, and the T0 outputs of that cycle still occur.
  - Otherwise: next state is T1.
- T1: read, reg_enable[22]. Next: T2.
- T2: enc_input[22], reg_enable[21]. Next: DEC. The IR is valid from DEC onward.
- DEC: no outputs. Dispatch on IR[31:27]:
  - OP_BR goes to BR3.
  - OP_JR goes to JR3.
  - OP_JAL goes to JAL3.
  - OP_HALT goes to HALT.
  - Any other opcode goes to T0.
- BR3: Gra, Rout, conIn; CON FF loads using IR[20:19].
- BR4: enc_input[20], reg_enable[24].
- BR5: Grc=0, enc_input[25], ALU_Sel=ALU_ADD, reg_enable[19].
- BR6: enc_input[19]; reg_enable[20] = CONFFOut, combinational from the FF, which is valid since BR4. Next: T0.
- JR3: Gra, Rout, reg_enable[20]. Next: T0.
- JAL3: enc_input[20], Rin with Gra/Grb/Grc all 0. The datapath select-encode routes this case to R15, so R15 ← PC (already incremented).
- JAL4: Gra, Rout, reg_enable[20], so PC ← R[ra]. Next: T0.
- HALT: run=0 and all control outputs 0. It is absorbing; only clr exits it.
- Invariants:
  - enc_input is one-hot or zero in every state.
  - Rout and any enc_input bit are never asserted together.
  - ALU_Sel=0 outside BR5.
- clr mid-instruction: returns to RST immediately; partial register updates are not undone.
- Instruction latency, in clocks from T0:
  - fetch+nop: 4.
  - jr: 5.
  - jal: 6.
  - br: 8.

Test Plan:
- Reset: clr=0 for 2 cycles mid-run → all outputs 0, present_state=4'hF, run=0. Release → next edge present_state=0, enc_input=32'h0010_0000, reg_enable=32'h0080_0000, incPC=1.
- Fetch of a nop (IR[31:27]=5'b11001) → states 0,1,2,3,0 on successive edges. T1 outputs read=1, reg_enable=32'h0040_0000. T2 outputs enc_input=32'h0040_0000, reg_enable=32'h0020_0000.
- br taken: IR opcode 10010, CONFFOut=1 from BR4 → BR3 asserts Gra=Rout=conIn=1, BR5 asserts ALU_Sel=6'd3 and reg_enable[19], BR6 asserts enc_input[19] and reg_enable[20]=1. Repeat with CONFFOut=0 → reg_enable=0 in BR6, and T0 still follows.
- jal: IR opcode 10100 → JAL3: enc_input=32'h0010_0000, Rin=1, Gra=0. JAL4: Gra=Rout=1, reg_enable=32'h0010_0000. Total 6 clocks T0→T0.
- halt / stop: IR opcode 11010 → HALT after DEC, run=0, stays 20 cycles. Separately, stop=1 during T0 → HALT next edge with no T1.
- Reset mid-br: drop clr during BR5 → asynchronous to RST with ALU_Sel=0 immediately, no waiting for the clock edge. Restart fetches normally.
